// File: rtl/fpm_seq_ctrl.sv
// Sequencing FSM for an iterative floating-point mantissa multiplier.
// Drives load / step / normalise enables and holds the result handshake.
module fpm_seq_ctrl #(
  parameter int MANT_W       = 24,
  parameter int BITS_PER_CYC = 1,
  localparam int ITER  = (MANT_W + BITS_PER_CYC - 1) / BITS_PER_CYC,
  localparam int CNT_W = $clog2(ITER + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic             bypass,
  input  logic             abort,
  input  logic             res_ready,
  output logic             res_valid,
  output logic             ld_en,
  output logic             step_en,
  output logic             norm_en,
  output logic [CNT_W-1:0] iter_cnt,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    LOAD    = 3'b001,
    COMPUTE = 3'b010,
    NORM    = 3'b011,
    DONE    = 3'b100
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  // Kept as a plain vector so unused encodings stay representable.
  logic [2:0]       state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;

  assign ready = !abort &&
                 (state_q == IDLE ||
                  (state_q == DONE && res_ready));
  assign accept   = start && ready;
  assign iter_cnt = cnt_q;
  assign state    = state_q;

  always_comb begin
    state_d   = state_e'(state_q);
    cnt_d     = '0;
    ld_en     = 1'b0;
    step_en   = 1'b0;
    norm_en   = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = LOAD;
      end
      LOAD: begin
        ld_en = 1'b1;
        if (abort)       state_d = IDLE;
        else if (bypass) state_d = DONE;
        else             state_d = COMPUTE;
      end
      COMPUTE: begin
        step_en = 1'b1;
        if (abort)              state_d = IDLE;
        else if (cnt_q == LAST) state_d = NORM;
        else                    cnt_d = cnt_q + CNT_W'(1);
      end
      NORM: begin
        norm_en = 1'b1;
        state_d = abort ? IDLE : DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = accept ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/fpm_seq_ctrl.md
FPM_SEQ_CTRL -- requirements
Module: fpm_seq_ctrl

Interface
REQ-001 The block SHALL have parameter MANT_W, default 24, meaning mantissa width in bits; legal range 4..64.
REQ-002 The block SHALL have parameter BITS_PER_CYC, default 1, meaning mantissa bits retired per COMPUTE cycle; legal values 1, 2.
REQ-003 The block SHALL derive ITER = ceil(MANT_W/BITS_PER_CYC) and CNT_W = clog2(ITER+1); both are local, not overridable.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 start  input  1  operation request; accepted when start && ready.
REQ-008 ready  output  1  block can accept start this cycle.
REQ-009 bypass  input  1  special-operand flag (zero/inf/NaN) from the operand classifier; sampled in LOAD only.
REQ-010 abort  input  1  cancel the in-flight operation.
REQ-011 res_ready  input  1  consumer accepts the result.
REQ-012 res_valid  output  1  result registers hold a valid product.
REQ-013 ld_en  output  1  load operand registers.
REQ-014 step_en  output  1  shift/accumulate enable for the datapath.
REQ-015 norm_en  output  1  normalise/round enable.
REQ-016 iter_cnt  output  CNT_W  COMPUTE iteration index.
REQ-017 state  output  3  current state encoding, for debug.

Function
REQ-018 State SHALL be registered; encodings IDLE=000, LOAD=001, COMPUTE=010, NORM=011, DONE=100; any other value SHALL go to IDLE on the next clock.
REQ-019 Outputs SHALL be Moore-decoded from state, except ready: ld_en=LOAD, step_en=COMPUTE, norm_en=NORM, res_valid=DONE.
REQ-020 ready SHALL equal !abort && (state==IDLE || (state==DONE && res_ready)).
REQ-021 IDLE: start && ready -> LOAD; otherwise stay in IDLE.
REQ-022 LOAD: bypass=1 -> DONE, skipping COMPUTE and NORM; bypass=0 -> COMPUTE with iter_cnt=0.
REQ-023 COMPUTE: iter_cnt SHALL increment by 1 per cycle; when iter_cnt==ITER-1 the next state SHALL be NORM and iter_cnt SHALL clear to 0.
REQ-024 NORM SHALL last exactly one cycle, then go to DONE.
REQ-025 DONE SHALL hold res_valid=1 until res_ready=1. On res_ready: start=1 -> LOAD (back-to-back, no IDLE bubble); start=0 -> IDLE.
REQ-026 abort=1 in LOAD, COMPUTE or NORM SHALL force IDLE on the next clock with iter_cnt=0; res_valid SHALL NOT assert for the aborted operation.
REQ-027 abort SHALL be ignored in DONE; in IDLE it SHALL only block acceptance of start.
REQ-028 Latency, start accepted at cycle T, no bypass: LOAD at T+1, COMPUTE T+2..T+1+ITER, NORM T+2+ITER, res_valid first high at T+3+ITER.
REQ-029 Latency with bypass: res_valid first high at T+2.
REQ-030 iter_cnt SHALL be 0 in every state other than COMPUTE.

Reset
REQ-031 When rst_n=0 at a clock edge: state=IDLE, iter_cnt=0. After that edge: ld_en=step_en=norm_en=res_valid=0, and ready=!abort.
REQ-032 Reset SHALL take priority over every other input, including reset asserted mid-COMPUTE or in DONE. No residual res_valid SHALL appear after reset.

Verification
REQ-033 Defaults, start pulsed at T, res_ready=1 -> ld_en at T+1; step_en T+2..T+25; norm_en T+26; res_valid T+27 for one cycle; then IDLE.
REQ-034 BITS_PER_CYC=2, MANT_W=24 -> ITER=12; res_valid first high at T+15.
REQ-035 bypass=1 during LOAD -> state sequence LOAD->DONE; step_en and norm_en never high; res_valid at T+2.
REQ-036 abort at COMPUTE iter_cnt=5 -> IDLE next cycle, iter_cnt=0, res_valid stays 0. A start in the same cycle as abort -> not accepted (ready=0).
REQ-037 DONE with res_ready=0 for 4 cycles -> res_valid held for 4 cycles. res_ready=1 with start=1 -> LOAD on the next cycle.
REQ-038 Force rst_n=0 mid-COMPUTE; also force state=111 -> both return to IDLE, iter_cnt=0, all enables 0.
